// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, then completes with a single-cycle response pulse.
// Storage is four byte-lane RAMs, so sub-word stores need no read-modify-write.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    count;

    // Transaction fields captured at the accept edge
    logic          write_reg;
    logic          unsigned_reg;
    logic          err_reg;
    logic [1:0]    size_reg;
    logic [1:0]    lo_reg;
    logic [AW-1:0] idx_reg;
    logic [31:0]   wdata_reg;

    logic          accept;
    logic          enter_resp;
    logic          cur_write;
    logic          cur_err;
    logic [1:0]    cur_size;
    logic [1:0]    cur_lo;
    logic [AW-1:0] cur_idx;
    logic [31:0]   cur_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic [31:0]   rd_word;

    // Misaligned, illegal-size and out-of-range requests are all rejected
    function automatic logic is_illegal(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        bad = ({1'b0, addr} >= ADDR_LIMIT);
        case (size)
            2'b00:   bad = bad;
            2'b01:   bad = bad | addr[0];
            2'b10:   bad = bad | (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign accept = req_valid && (state == IDLE);

    // The transaction completing this edge comes straight from the request
    // pins when there are no wait states, otherwise from the captured copy.
    always_comb begin
        cur_write = write_reg;
        cur_err   = err_reg;
        cur_size  = size_reg;
        cur_lo    = lo_reg;
        cur_idx   = idx_reg;
        cur_wdata = wdata_reg;
        if (state == IDLE) begin
            cur_write = req_write;
            cur_err   = is_illegal(req_size, req_addr);
            cur_size  = req_size;
            cur_lo    = req_addr[1:0];
            cur_idx   = req_addr[AW+1:2];
            cur_wdata = req_wdata;
        end
    end

    assign enter_resp = ((state == IDLE) && accept && (WAIT_STATES == 0)) ||
                        ((state == WAIT) && (count == 4'd1));
    assign mem_we     = enter_resp && cur_write && !cur_err && !rst;
    assign mem_re     = enter_resp && !cur_write && !cur_err && !rst;

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = cur_wdata;
        case (cur_size)
            2'b00: begin
                lane_en   = 4'b0001 << cur_lo;
                lane_data = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                lane_en   = cur_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                lane_en   = 4'b1111;
                lane_data = cur_wdata;
            end
            default: begin
                lane_en   = 4'b0000;
                lane_data = cur_wdata;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_byte;

            // One byte lane: write on the edge entering RESP, registered read
            always_ff @(posedge clk) begin
                if (mem_we && lane_en[gi]) begin
                    lane_mem[cur_idx] <= lane_data[8*gi +: 8];
                end
                if (mem_re) begin
                    rd_byte <= lane_mem[cur_idx];
                end
            end
        end
    endgenerate

    assign rd_word = {g_lane[3].rd_byte, g_lane[2].rd_byte,
                      g_lane[1].rd_byte, g_lane[0].rd_byte};

    // Control FSM and request capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= 4'd0;
            write_reg    <= 1'b0;
            unsigned_reg <= 1'b0;
            err_reg      <= 1'b0;
            size_reg     <= 2'b00;
            lo_reg       <= 2'b00;
            idx_reg      <= '0;
            wdata_reg    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        write_reg    <= req_write;
                        unsigned_reg <= req_unsigned;
                        err_reg      <= is_illegal(req_size, req_addr);
                        size_reg     <= req_size;
                        lo_reg       <= req_addr[1:0];
                        idx_reg      <= req_addr[AW+1:2];
                        wdata_reg    <= req_wdata;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                            count <= 4'd0;
                        end else begin
                            state <= WAIT;
                            count <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_error = resp_valid && err_reg;

    // Load result: select the addressed byte/half and extend it
    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        resp_rdata = 32'd0;
        sel_byte   = 8'd0;
        sel_half   = lo_reg[1] ? rd_word[31:16] : rd_word[15:0];
        case (lo_reg)
            2'd0:    sel_byte = rd_word[7:0];
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        if (resp_valid && !err_reg && !write_reg) begin
            case (size_reg)
                2'b00:   resp_rdata = {{24{sel_byte[7] & ~unsigned_reg}}, sel_byte};
                2'b01:   resp_rdata = {{16{sel_half[15] & ~unsigned_reg}}, sel_half};
                2'b10:   resp_rdata = rd_word;
                default: resp_rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Three instances cover WAIT_STATES
// of 1, 3 and 0; expected responses go into a scoreboard queue at accept
// time and are popped when the response pulse appears.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          [3];
    logic        req_valid    [3];
    logic        req_write    [3];
    logic [31:0] req_addr     [3];
    logic [31:0] req_wdata    [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic        req_ready    [3];
    logic        resp_valid   [3];
    logic [31:0] resp_rdata   [3];
    logic        resp_error   [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            data_mem_responder #(
                .DEPTH_WORDS (1024),
                .WAIT_STATES ((gi == 0) ? 1 : ((gi == 1) ? 3 : 0))
            ) u_dut (
                .clk          (clk),
                .rst          (rst[gi]),
                .req_valid    (req_valid[gi]),
                .req_write    (req_write[gi]),
                .req_addr     (req_addr[gi]),
                .req_wdata    (req_wdata[gi]),
                .req_size     (req_size[gi]),
                .req_unsigned (req_unsigned[gi]),
                .req_ready    (req_ready[gi]),
                .resp_valid   (resp_valid[gi]),
                .resp_rdata   (resp_rdata[gi]),
                .resp_error   (resp_error[gi])
            );
        end
    endgenerate

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic fail_now(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: timed out waiting on the DUT", tag);
    endtask

    // One full transaction: present, wait for accept, scramble the pins,
    // then wait for the response and compare it with the scoreboard.
    task automatic do_req(input int k, input string tag, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        int   n;
        bit   seen;
        req_valid[k]    = 1'b1;
        req_write[k]    = wr;
        req_addr[k]     = addr;
        req_wdata[k]    = wdata;
        req_size[k]     = size;
        req_unsigned[k] = uns;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready[k]) begin
            fail_now({tag, "_ready"});
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = ws_of(k) + 1;
        sb.push_back(e);
        #1;
        req_valid[k]    = 1'b0;
        req_write[k]    = ~wr;
        req_addr[k]     = ~addr;
        req_wdata[k]    = ~wdata;
        req_size[k]     = 2'b11;
        req_unsigned[k] = ~uns;
        seen = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (resp_valid[k]) begin
                e = sb.pop_front();
                check({tag, "_lat"}, 32'(c), 32'(e.lat));
                check({tag, "_rdata"}, resp_rdata[k], e.rdata);
                check({tag, "_err"}, {31'd0, resp_error[k]}, {31'd0, e.err});
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            fail_now({tag, "_resp"});
            void'(sb.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, {30'd0, resp_valid[k], resp_error[k]}, 32'd0);
        check({tag, "_idle_rdata"}, resp_rdata[k], 32'd0);
    endtask

    initial begin
        bit any_resp;
        bit pre_ready;
        exp_t e;

        for (int k = 0; k < 3; k++) begin
            rst[k]          = 1'b1;
            req_valid[k]    = 1'b0;
            req_write[k]    = 1'b0;
            req_addr[k]     = 32'd0;
            req_wdata[k]    = 32'd0;
            req_size[k]     = 2'b00;
            req_unsigned[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready[0]}, 32'd1);
        check("rst_valid", {31'd0, resp_valid[0]}, 32'd0);
        check("rst_rdata", resp_rdata[0], 32'd0);
        check("rst_error", {31'd0, resp_error[0]}, 32'd0);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // WAIT_STATES = 1: word store/load and extension cases
        do_req(0, "sw10",  1'b1, 32'h10, 32'h80FF7F01, 2'b10, 1'b0, 32'h0,        1'b0);
        do_req(0, "lw10",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h80FF7F01, 1'b0);
        do_req(0, "lb10",  1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'h00000001, 1'b0);
        do_req(0, "lb11",  1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 32'h0000007F, 1'b0);
        do_req(0, "lb12",  1'b0, 32'h12, 32'h0,        2'b00, 1'b0, 32'hFFFFFFFF, 1'b0);
        do_req(0, "lb13",  1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
        do_req(0, "lbu10", 1'b0, 32'h10, 32'h0,        2'b00, 1'b1, 32'h00000001, 1'b0);
        do_req(0, "lbu11", 1'b0, 32'h11, 32'h0,        2'b00, 1'b1, 32'h0000007F, 1'b0);
        do_req(0, "lbu12", 1'b0, 32'h12, 32'h0,        2'b00, 1'b1, 32'h000000FF, 1'b0);
        do_req(0, "lbu13", 1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0);
        do_req(0, "sh12",  1'b1, 32'h12, 32'h0000BEEF, 2'b01, 1'b0, 32'h0,        1'b0);
        do_req(0, "lw10b", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hBEEF7F01, 1'b0);
        do_req(0, "lh12",  1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'hFFFFBEEF, 1'b0);
        do_req(0, "lhu12", 1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 32'h0000BEEF, 1'b0);

        // Rejected requests must not touch memory
        do_req(0, "sw0",     1'b1, 32'h0,    32'h11223344, 2'b10, 1'b0, 32'h0, 1'b0);
        do_req(0, "err_sw13", 1'b1, 32'h13,  32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b1);
        do_req(0, "err_lh11", 1'b0, 32'h11,  32'h0,        2'b01, 1'b0, 32'h0, 1'b1);
        do_req(0, "err_sz3",  1'b1, 32'h0,   32'hDEADBEEF, 2'b11, 1'b0, 32'h0, 1'b1);
        do_req(0, "err_oor",  1'b1, 32'h1000, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b1);
        do_req(0, "reread0",  1'b0, 32'h0,   32'h0,        2'b10, 1'b0, 32'h11223344, 1'b0);
        do_req(0, "reread10", 1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hBEEF7F01, 1'b0);

        // WAIT_STATES = 3: reset aborts an in-flight store
        do_req(1, "sw20", 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 1'b0);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'h12345678;
        req_size[1]  = 2'b10;
        check("abort_ready", {31'd0, req_ready[1]}, 32'd1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        #1;
        check("abort_rst_ready", {31'd0, req_ready[1]}, 32'd1);
        check("abort_rst_valid", {30'd0, resp_valid[1], resp_error[1]}, 32'd0);
        check("abort_rst_rdata", resp_rdata[1], 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_rst_ready2", {31'd0, req_ready[1]}, 32'd1);
        rst[1] = 1'b0;
        any_resp = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (resp_valid[1]) any_resp = 1'b1;
        end
        check("abort_no_resp", {31'd0, any_resp}, 32'd0);
        do_req(1, "lw20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);

        // WAIT_STATES = 0: request held continuously
        do_req(2, "sw4", 1'b1, 32'h4, 32'h0000A5A5, 2'b10, 1'b0, 32'h0, 1'b0);
        req_valid[2]    = 1'b1;
        req_write[2]    = 1'b0;
        req_addr[2]     = 32'h4;
        req_size[2]     = 2'b10;
        req_unsigned[2] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            pre_ready = req_ready[2];
            @(posedge clk);
            if (pre_ready) begin
                e.rdata = 32'h0000A5A5;
                e.err   = 1'b0;
                e.lat   = 1;
                sb.push_back(e);
            end
            #1;
            check($sformatf("b2b_ready_%0d", i), {31'd0, req_ready[2]}, {31'd0, (i % 2 == 0)});
            check($sformatf("b2b_valid_%0d", i), {31'd0, resp_valid[2]}, {31'd0, (i % 2 == 1)});
            if (resp_valid[2]) begin
                if (sb.size() == 0) begin
                    fail_now($sformatf("b2b_unexpected_%0d", i));
                end else begin
                    e = sb.pop_front();
                    check($sformatf("b2b_rdata_%0d", i), resp_rdata[2], e.rdata);
                end
            end
        end
        req_valid[2] = 1'b0;
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words of storage.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, range 0-15, giving extra cycles inserted before each response.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-006 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-009 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 The block SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-011 The block SHALL have port req_ready, output, 1 bit: the request is accepted this cycle.
REQ-012 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port resp_rdata, output, 32 bits: load result, already extended.
REQ-014 The block SHALL have port resp_error, output, 1 bit: the completed request was rejected.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted when req_valid and req_ready are both 1; all req_* fields are captured at that edge.
REQ-018 Acceptance SHALL move IDLE to WAIT with the counter loaded to WAIT_STATES; if WAIT_STATES = 0, it SHALL go directly to RESP.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter reads 0.
REQ-020 In RESP, resp_valid SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-021 Response latency SHALL be WAIT_STATES+1 cycles after the accept edge.
REQ-022 req_* inputs SHALL be ignored outside IDLE.
REQ-023 The block SHALL reject the request, setting resp_error = 1, if any of these holds: req_size = 11; half with addr[0] = 1; word with addr[1:0] != 0; addr >= DEPTH_WORDS*4.
REQ-024 An errored request SHALL leave memory unmodified and return resp_rdata = 0.
REQ-025 The storage write SHALL occur on the edge entering RESP, never earlier.
REQ-026 Write lanes SHALL be as follows: byte writes lane addr[1:0] from wdata[7:0]; half writes lanes addr[1]*2 and +1 from wdata[15:0]; word writes all four lanes; other lanes are preserved.
REQ-027 Loads SHALL read the word addr[31:2], select the byte or half by addr[1:0], and extend it to 32 bits per req_unsigned; for word loads req_unsigned is ignored.
REQ-028 Stores SHALL return resp_rdata = 0 with resp_error = 0 when legal.
REQ-029 resp_rdata and resp_error SHALL be 0 whenever resp_valid = 0.
REQ-030 A load SHALL return memory contents as of the RESP edge, so a store completing immediately before it is visible.
REQ-031 The minimum back-to-back spacing SHALL be WAIT_STATES+2 cycles between accepts.

Reset
REQ-032 While rst = 1: state = IDLE, counter = 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_error = 0.
REQ-033 Asserting rst in WAIT or RESP SHALL abort the transaction; an aborted store SHALL NOT write memory.
REQ-034 Memory contents SHALL NOT be cleared by rst.
REQ-035 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-036 The bench SHALL run this scenario: WAIT_STATES = 1; word store 0x80FF7F01 to 0x10, then word load 0x10 -> resp_valid exactly 2 cycles after each accept; load returns 0x80FF7F01 with resp_error = 0.
REQ-037 The bench SHALL run this scenario: byte loads at 0x10-0x13 with req_unsigned = 0 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; with req_unsigned = 1 the same loads -> 0x01, 0x7F, 0xFF, 0x80.
REQ-038 The bench SHALL run this scenario: half store 0xBEEF to 0x12, then word load 0x10 -> 0xBEEF7F01; half signed load at 0x12 -> 0xFFFFBEEF.
REQ-039 The bench SHALL run this scenario: word store to 0x13, half load at 0x11, size 11 at 0x0, and addr = DEPTH_WORDS*4 -> each returns resp_error = 1 and resp_rdata = 0; memory is unchanged, confirmed by reread.
REQ-040 The bench SHALL run this scenario: WAIT_STATES = 3; assert rst one cycle after accepting a word store of 0x12345678 to 0x20 -> no resp_valid; a later load of 0x20 returns the prior value; req_ready = 1 during reset.
REQ-041 The bench SHALL run this scenario: WAIT_STATES = 0; hold req_valid high continuously -> accepts every 2 cycles, resp_valid 1 cycle after each accept, req_ready low in the RESP cycle.
